// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the CPU RAM bus. Serves a word-addressed backing
// RAM plus a 16-word memory-mapped I/O page:
//   offset 0 TICK   free-running 16-bit counter (write loads it)
//   offset 1 PORT   output port register driven on io_out
//   offset 2 TXDATA write pushes RAMin[7:0] into a 4-deep byte FIFO
//   offset 3 STATUS {10'b0, count[2:0], ovf, full, empty}; write RAMin[2]=1 clears ovf
//   offset 4..15    read as zero, writes ignored
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   RAMaddr, RAMin    word address and write data from the CPU
//   we                write enable, committed on the rising edge
//   RAMout            registered read data (one cycle latency)
//   io_out            output port register
//   tx_data, tx_valid FIFO head byte and non-empty flag
//   tx_ready          consumer accepts the head byte this cycle
module mem_responder #(
  parameter int          AW      = 10,
  parameter logic [15:0] IO_BASE = 16'hFFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] RAMaddr,
  input  logic [15:0] RAMin,
  input  logic        we,
  output logic [15:0] RAMout,
  output logic [15:0] io_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int DEPTH = 1 << AW;

  // Backing RAM, deliberately without reset.
  logic [15:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          io_sel;
  logic [3:0]    io_off;

  // Widened compare so a page near the top of the address space cannot overflow.
  assign io_sel = ({1'b0, RAMaddr} >= {1'b0, IO_BASE}) &&
                  ({1'b0, RAMaddr} <= ({1'b0, IO_BASE} + 17'd15));
  assign io_off = RAMaddr[3:0] - IO_BASE[3:0];
  assign idx    = RAMaddr[AW-1:0];

  logic ram_we, wr_tick, wr_port, wr_tx, wr_stat;
  assign ram_we  = we && !io_sel;
  assign wr_tick = we && io_sel && (io_off == 4'd0);
  assign wr_port = we && io_sel && (io_off == 4'd1);
  assign wr_tx   = we && io_sel && (io_off == 4'd2);
  assign wr_stat = we && io_sel && (io_off == 4'd3);

  // I/O state
  logic [15:0] tick_reg, tick_next;
  logic [15:0] io_out_next;
  logic [7:0]  fifo_reg [4];
  logic [1:0]  rptr_reg, rptr_next;
  logic [1:0]  wptr_reg, wptr_next;
  logic [2:0]  count_reg, count_next;
  logic        ovf_reg, ovf_next;
  logic [15:0] rd_next;

  logic full, empty, pop, push, drop;
  assign full  = (count_reg == 3'd4);
  assign empty = (count_reg == 3'd0);
  assign pop   = !empty && tx_ready;
  // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
  assign push  = wr_tx && (!full || pop);
  assign drop  = wr_tx && full && !pop;

  assign tx_valid = !empty;
  assign tx_data  = fifo_reg[rptr_reg];

  logic [15:0] status;
  assign status = {10'b0, count_reg, ovf_reg, full, empty};

  // Per-entry FIFO write strobes.
  logic [3:0] ent_we;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ent
      assign ent_we[gi] = push && (wptr_reg == 2'(gi));
    end
  endgenerate

  // FIFO storage carries no reset; only pointers and count define validity.
  // Reset gating keeps a push coincident with reset from landing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ent_we[i] && !reset) fifo_reg[i] <= RAMin[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[idx] <= RAMin;
  end

  always_comb begin
    rd_next     = 16'h0000;
    tick_next   = tick_reg + 16'd1;
    io_out_next = io_out;
    rptr_next   = rptr_reg;
    wptr_next   = wptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;

    // Read data: RAM is write-first, I/O returns pre-edge state.
    if (!io_sel) begin
      rd_next = we ? RAMin : mem[idx];
    end else begin
      case (io_off)
        4'd0:    rd_next = tick_reg;
        4'd1:    rd_next = io_out;
        4'd3:    rd_next = status;
        default: rd_next = 16'h0000;
      endcase
    end

    if (wr_tick) tick_next = RAMin;
    if (wr_port) io_out_next = RAMin;

    if (pop)  rptr_next = rptr_reg + 2'd1;
    if (push) wptr_next = wptr_reg + 2'd1;
    case ({push, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase

    // Clear first so that a simultaneous overflow wins.
    if (wr_stat && RAMin[2]) ovf_next = 1'b0;
    if (drop)                ovf_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RAMout    <= 16'h0000;
      io_out    <= 16'h0000;
      tick_reg  <= 16'h0000;
      rptr_reg  <= 2'd0;
      wptr_reg  <= 2'd0;
      count_reg <= 3'd0;
      ovf_reg   <= 1'b0;
    end else begin
      RAMout    <= rd_next;
      io_out    <= io_out_next;
      tick_reg  <= tick_next;
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

endmodule
